// File: rtl/alu_pkg.sv
// Shared types for the ALU issue controller: op codes, condition codes, NZCV flags, FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_MUL = 4'b0010
  } alu_op_e;

  typedef enum logic [3:0] {
    CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
    CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
    CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
    CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } issue_state_e;

endpackage

// File: rtl/alu_cond_eval.sv
// Condition-code evaluator: purely combinational (cond, NZCV) -> pass, zero latency.
// No flow control; consumed by the issue FSM at request acceptance.
module alu_cond_eval
  import alu_pkg::*;
(
  input  cond_e  cond,
  input  flags_t flg,
  output logic   pass
);

  always_comb begin
    pass = 1'b0;
    case (cond)
      CC_EQ: pass = flg.z;
      CC_NE: pass = ~flg.z;
      CC_CS: pass = flg.c;
      CC_CC: pass = ~flg.c;
      CC_MI: pass = flg.n;
      CC_PL: pass = ~flg.n;
      CC_VS: pass = flg.v;
      CC_VC: pass = ~flg.v;
      CC_HI: pass = flg.c & ~flg.z;
      CC_LS: pass = ~flg.c | flg.z;
      CC_GE: pass = (flg.n == flg.v);
      CC_LT: pass = (flg.n != flg.v);
      CC_GT: pass = ~flg.z & (flg.n == flg.v);
      CC_LE: pass = flg.z | (flg.n != flg.v);
      CC_AL: pass = 1'b1;
      CC_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accept op, evaluate condition, drive ALU, capture result/flags, respond.
// Latency 2 edges (MUL: 2+MUL_LAT); holds response until rsp_ready. ALU_ISSUE_STATS_EN adds exec/skip counters.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [3:0]       req_cond,
  input  logic             req_setflags,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_exec,
  output logic [3:0]       flags
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]      exec_cnt,
  output logic [15:0]      skip_cnt
`endif
);

  localparam int CNT_W = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);

  issue_state_e     state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic             setflags_q, setflags_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  flags_t           flags_q, flags_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_exec_q, rsp_exec_d;
  logic             cond_pass;
  logic             is_mul;

  alu_cond_eval u_cond_eval (
    .cond (cond_e'(req_cond)),
    .flg  (flags_q),
    .pass (cond_pass)
  );

  assign is_mul = (alu_op_q == OP_MUL);

  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    setflags_d = setflags_q;
    pass_d     = pass_q;
    cnt_d      = cnt_q;
    flags_d    = flags_q;
    rsp_data_d = rsp_data_q;
    rsp_exec_d = rsp_exec_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          alu_a_d    = req_a;
          alu_b_d    = req_b;
          alu_op_d   = req_op;
          setflags_d = req_setflags;
          pass_d     = cond_pass;
          cnt_d      = CNT_W'(MUL_LAT);
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Only an executed MUL waits out the multiplier; skipped ops respond at once.
        if (pass_q && is_mul && (cnt_q != '0)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_RESP;
          if (pass_q) begin
            rsp_data_d = alu_out;
            rsp_exec_d = 1'b1;
            if (setflags_q) begin
              case (alu_op_q)
                OP_ADD, OP_SUB: flags_d = '{n: alu_n, z: alu_z, c: alu_c, v: alu_v};
                OP_MUL: begin
                  flags_d.n = alu_n;
                  flags_d.z = alu_z;
                end
                default: flags_d = flags_q;
              endcase
            end
          end else begin
            rsp_data_d = '0;
            rsp_exec_d = 1'b0;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      setflags_q <= 1'b0;
      pass_q     <= 1'b0;
      cnt_q      <= '0;
      flags_q    <= '0;
      rsp_data_q <= '0;
      rsp_exec_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      setflags_q <= setflags_d;
      pass_q     <= pass_d;
      cnt_q      <= cnt_d;
      flags_q    <= flags_d;
      rsp_data_q <= rsp_data_d;
      rsp_exec_q <= rsp_exec_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_exec  = rsp_exec_q;
  assign flags     = flags_q;

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] exec_cnt_q, exec_cnt_d;
  logic [15:0] skip_cnt_q, skip_cnt_d;

  // Counted on the response handshake; both saturate at all-ones.
  always_comb begin
    exec_cnt_d = exec_cnt_q;
    skip_cnt_d = skip_cnt_q;
    if ((state_q == ST_RESP) && rsp_ready) begin
      if (rsp_exec_q) begin
        if (exec_cnt_q != 16'hFFFF) exec_cnt_d = exec_cnt_q + 16'd1;
      end else begin
        if (skip_cnt_q != 16'hFFFF) skip_cnt_d = skip_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exec_cnt_q <= '0;
      skip_cnt_q <= '0;
    end else begin
      exec_cnt_q <= exec_cnt_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end

  assign exec_cnt = exec_cnt_q;
  assign skip_cnt = skip_cnt_q;
`endif

endmodule
